// File: rtl/csa_arbiter_pkg.sv
// csa_arbiter_pkg
//   Shared types and constants for the carry-save adder arbiter.
//   - state_t    : sequencer state (IDLE / EXEC / RESP), 2-bit encoding
//   - DEF_NREQ   : default requester count
//   - DEF_OP_W   : default operand width
//   - res_w()    : result width for a given operand width (OP_W+2)
package csa_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_OP_W = 4;

    // Three OP_W-bit operands sum to at most 3*(2^OP_W-1), which needs OP_W+2 bits.
    function automatic int res_w(input int op_w);
        return op_w + 2;
    endfunction

endpackage

// File: rtl/csa_arbiter_rr_pick.sv
// csa_arbiter_rr_pick (module rr_pick)
//   Combinational round-robin picker. Searches i_req starting at i_ptr,
//   wrapping modulo NREQ; the first set bit wins.
//   Ports:
//     i_req  [NREQ-1:0]  request levels
//     i_ptr  [IW-1:0]    index with highest priority this round
//     o_gnt  [NREQ-1:0]  one-hot winner (zero when no request)
//     o_idx  [IW-1:0]    winner index
//     o_vld              any request present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_vld
);

    int w_j;

    // Walk the search order backwards so the earliest candidate overwrites
    // any later one, leaving the highest-priority winner.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_j   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % NREQ;
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j[IW-1:0];
                o_vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csa_arbiter.sv
// csa_arbiter
//   Shares one three-operand carry-save adder among NREQ requesters.
//   IDLE picks a winner round-robin and latches its operands, EXEC registers
//   the sum and pulses done, RESP drops the grant and advances the pointer.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     req    [NREQ]       per-requester request level
//     a/b/c_flat          operands, requester i owns [i*OP_W +: OP_W]
//     gnt    [NREQ]       registered one-hot grant
//     done   [NREQ]       registered one-cycle completion pulse
//     sum    [OP_W+2]     result of the last completed transaction
//     busy                state is not IDLE
module csa_arbiter
    import csa_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int OP_W = DEF_OP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*OP_W-1:0]   a_flat,
    input  logic [NREQ*OP_W-1:0]   b_flat,
    input  logic [NREQ*OP_W-1:0]   c_flat,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [res_w(OP_W)-1:0] sum,
    output logic                   busy
);

    localparam int RW = res_w(OP_W);
    localparam int IW = $clog2(NREQ);

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic [RW-1:0]     r_sum;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_idx;
    logic [OP_W-1:0]   r_a, r_b, r_c;

    logic [NREQ-1:0]   w_pick;
    logic [IW-1:0]     w_idx;
    logic              w_vld;
    logic [OP_W-1:0]   w_a, w_b, w_c;
    logic [OP_W-1:0]   w_save, w_carry;
    logic [RW-1:0]     w_x, w_y, w_sum;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick),
        .o_idx (w_idx),
        .o_vld (w_vld)
    );

    // Operand mux driven by the one-hot pick.
    always_comb begin
        w_a = '0;
        w_b = '0;
        w_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) begin
                w_a = a_flat[i*OP_W +: OP_W];
                w_b = b_flat[i*OP_W +: OP_W];
                w_c = c_flat[i*OP_W +: OP_W];
            end
        end
    end

    // Carry-save reduction: one full adder per column, then a ripple add of
    // the save vector and the carry vector shifted up one column.
    always_comb begin
        logic cy;
        cy = 1'b0;
        for (int i = 0; i < OP_W; i++) begin
            w_save[i]  = r_a[i] ^ r_b[i] ^ r_c[i];
            w_carry[i] = (r_a[i] & r_b[i]) | (r_a[i] & r_c[i]) | (r_b[i] & r_c[i]);
        end
        w_x = {2'b00, w_save};
        w_y = {1'b0, w_carry, 1'b0};
        for (int i = 0; i < RW; i++) begin
            w_sum[i] = w_x[i] ^ w_y[i] ^ cy;
            cy       = (w_x[i] & w_y[i]) | (cy & (w_x[i] ^ w_y[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_sum   <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_vld) begin
                        r_gnt   <= w_pick;
                        r_idx   <= w_idx;
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_c     <= w_c;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_sum   <= w_sum;
                    r_done  <= r_gnt;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_done  <= '0;
                    r_gnt   <= '0;
                    // Next search starts just past the requester we served.
                    r_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign sum  = r_sum;
    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_csa_arbiter.sv
module tb_csa_arbiter;

    localparam int NREQ = 4;
    localparam int OP_W = 4;
    localparam int RW   = OP_W + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*OP_W-1:0] a_flat, b_flat, c_flat;
    logic [NREQ-1:0]      gnt, done;
    logic [RW-1:0]        sum;
    logic                 busy;

    int n_vec = 0;
    int n_bad = 0;

    csa_arbiter #(.NREQ(NREQ), .OP_W(OP_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .c_flat (c_flat),
        .gnt    (gnt),
        .done   (done),
        .sum    (sum),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // chg[0]: overwrite operands with all-ones after grant; chg[1]: drop req after grant
    typedef struct {
        logic [NREQ-1:0]      req;
        logic [NREQ*OP_W-1:0] a, b, c;
        logic [1:0]           chg;
        logic [NREQ-1:0]      gnt;
        logic [RW-1:0]        sum;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic invariants(input string nm);
        chk({nm, " gnt_onehot0"}, int'($onehot0(gnt)), 1);
        chk({nm, " done_in_gnt"}, int'((done & ~gnt) == '0), 1);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        string nm;
        nm = $sformatf("v%0d", n);
        req = v.req; a_flat = v.a; b_flat = v.b; c_flat = v.c;
        tick();  // E0
        chk({nm, " E0 gnt"}, int'(gnt), int'(v.gnt));
        chk({nm, " E0 busy"}, int'(busy), 1);
        chk({nm, " E0 done"}, int'(done), 0);
        if (v.chg[0]) begin a_flat = '1; b_flat = '1; c_flat = '1; end
        if (v.chg[1]) req = '0;
        tick();  // E1
        chk({nm, " E1 done"}, int'(done), int'(v.gnt));
        chk({nm, " E1 sum"}, int'(sum), int'(v.sum));
        chk({nm, " E1 busy"}, int'(busy), 1);
        invariants({nm, " E1"});
        tick();  // E2
        chk({nm, " E2 done"}, int'(done), 0);
        chk({nm, " E2 gnt"}, int'(gnt), 0);
        chk({nm, " E2 busy"}, int'(busy), 0);
        chk({nm, " E2 sum_hold"}, int'(sum), int'(v.sum));
    endtask

    initial begin
        // Operand sets: 4321/8765/CBA9 gives lane sums 15,18,21,24.
        tbl[0]  = '{4'b0001, 16'h000F, 16'h000F, 16'h000F, 2'b00, 4'b0001, 6'd45};
        tbl[1]  = '{4'b1111, 16'h4321, 16'h8765, 16'hCBA9, 2'b00, 4'b0010, 6'd18};
        tbl[2]  = '{4'b1111, 16'h4321, 16'h8765, 16'hCBA9, 2'b00, 4'b0100, 6'd21};
        tbl[3]  = '{4'b1111, 16'h4321, 16'h8765, 16'hCBA9, 2'b00, 4'b1000, 6'd24};
        tbl[4]  = '{4'b1111, 16'h4321, 16'h8765, 16'hCBA9, 2'b00, 4'b0001, 6'd15};
        tbl[5]  = '{4'b1001, 16'h4321, 16'h8765, 16'hCBA9, 2'b00, 4'b1000, 6'd24};
        tbl[6]  = '{4'b1001, 16'h4321, 16'h8765, 16'hCBA9, 2'b00, 4'b0001, 6'd15};
        tbl[7]  = '{4'b1001, 16'h4321, 16'h8765, 16'hCBA9, 2'b00, 4'b1000, 6'd24};
        tbl[8]  = '{4'b0100, 16'h0300, 16'h0400, 16'h0500, 2'b01, 4'b0100, 6'd12};
        tbl[9]  = '{4'b0010, 16'h0090, 16'h00D0, 16'h0000, 2'b10, 4'b0010, 6'd22};
        tbl[10] = '{4'b1000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 4'b1000, 6'd0};
        tbl[11] = '{4'b0110, 16'h00F0, 16'h0000, 16'h0010, 2'b00, 4'b0010, 6'd16};
        tbl[12] = '{4'b0110, 16'h0700, 16'h0700, 16'h0700, 2'b00, 4'b0100, 6'd21};
        tbl[13] = '{4'b0110, 16'h0A00, 16'h0B00, 16'h0C00, 2'b11, 4'b0100, 6'd33};

        rst = 1'b1; req = '0; a_flat = '0; b_flat = '0; c_flat = '0;
        tick();
        tick();
        chk("rst gnt", int'(gnt), 0);
        chk("rst done", int'(done), 0);
        chk("rst sum", int'(sum), 0);
        chk("rst busy", int'(busy), 0);
        rst = 1'b0;

        // No request: stays idle.
        tick();
        tick();
        chk("idle gnt", int'(gnt), 0);
        chk("idle busy", int'(busy), 0);

        // tbl[13] follows tbl[12]: ptr=3, req 0110 -> search 3,0,1 -> 1 wins.
        tbl[13].gnt = 4'b0010;
        tbl[13].a = 16'h00A0; tbl[13].b = 16'h00B0; tbl[13].c = 16'h00C0;
        for (int i = 0; i < 14; i++) run_vec(i, tbl[i]);

        // Reset during EXEC: ptr is 2 here, req 0100 -> lane 2 granted,
        // then reset at the EXEC edge discards it.
        req = 4'b0100; a_flat = 16'h0100; b_flat = 16'h0100; c_flat = 16'h0100;
        tick();
        chk("rexec E0 gnt", int'(gnt), 4'b0100);
        rst = 1'b1;
        tick();
        chk("rexec done", int'(done), 0);
        chk("rexec gnt", int'(gnt), 0);
        chk("rexec sum", int'(sum), 0);
        chk("rexec busy", int'(busy), 0);
        rst = 1'b0;
        req = 4'b1111; a_flat = 16'h4321; b_flat = 16'h8765; c_flat = 16'hCBA9;
        tick();
        chk("rexec ptr0 gnt", int'(gnt), 4'b0001);
        tick();
        chk("rexec ptr0 done", int'(done), 4'b0001);
        chk("rexec ptr0 sum", int'(sum), 15);
        tick();
        chk("rexec ptr0 idle", int'(busy), 0);
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
